// File: rtl/cordic_vectoring_if.sv
// Start/busy/done handshake and operand/result bus for the CORDIC vectoring unit.
interface cordic_vectoring_if #(
  parameter int unsigned SZ = 16
);
  logic                 start;
  logic signed [SZ-1:0] x_in;
  logic signed [SZ-1:0] y_in;
  logic                 busy;
  logic                 done;
  logic [31:0]          angle;
  logic [SZ:0]          magnitude;

  modport master (
    output start, x_in, y_in,
    input  busy, done, angle, magnitude
  );

  modport slave (
    input  start, x_in, y_in,
    output busy, done, angle, magnitude
  );
endinterface

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: (x, y) -> atan2 as a 32-bit binary angle
// plus the gain-scaled magnitude. One micro-rotation per clock.
module cordic_vectoring #(
  parameter int unsigned SZ   = 16,
  parameter int unsigned ITER = 16
) (
  input logic               clock,
  input logic               reset,
  cordic_vectoring_if.slave bus
);

  localparam int unsigned W  = SZ + 2;
  localparam int unsigned CW = 5;
  localparam int unsigned AW = 32;
  localparam int unsigned MW = SZ + 1;

  typedef enum logic [1:0] {IDLE, ITERATE, DONE} state_t;

  state_t               state_q, state_d;
  logic signed [W-1:0]  x_q, x_d;
  logic signed [W-1:0]  y_q, y_d;
  logic [AW-1:0]        z_q, z_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 zero_q, zero_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [AW-1:0]        angle_q, angle_d;
  logic [MW-1:0]        mag_q, mag_d;

  logic signed [W-1:0]  x_ext_c, y_ext_c;
  logic signed [W-1:0]  x_sh_c, y_sh_c;
  logic signed [W-1:0]  x_rot_c, y_rot_c;
  logic [AW-1:0]        z_rot_c;
  logic [MW-1:0]        mag_sat_c;

  // Arctangent table, atan(2^-i) in binary-angle units.
  function automatic logic [AW-1:0] atan_lut(input logic [CW-1:0] i);
    case (i)
      5'd0:    atan_lut = 32'h2000_0000;
      5'd1:    atan_lut = 32'h12E4_051E;
      5'd2:    atan_lut = 32'h09FB_385B;
      5'd3:    atan_lut = 32'h0511_11D4;
      5'd4:    atan_lut = 32'h028B_0D43;
      5'd5:    atan_lut = 32'h0145_D7E1;
      5'd6:    atan_lut = 32'h00A2_F61E;
      5'd7:    atan_lut = 32'h0051_7C55;
      5'd8:    atan_lut = 32'h0028_BE53;
      5'd9:    atan_lut = 32'h0014_5F2F;
      5'd10:   atan_lut = 32'h000A_2F98;
      5'd11:   atan_lut = 32'h0005_17CC;
      5'd12:   atan_lut = 32'h0002_8BE6;
      5'd13:   atan_lut = 32'h0001_45F3;
      5'd14:   atan_lut = 32'h0000_A2FA;
      5'd15:   atan_lut = 32'h0000_517D;
      default: atan_lut = 32'h0000_0000;
    endcase
  endfunction

  // Operand sign extension; two guard bits let -2^(SZ-1) negate cleanly.
  always_comb begin
    x_ext_c = {{2{bus.x_in[SZ-1]}}, bus.x_in};
    y_ext_c = {{2{bus.y_in[SZ-1]}}, bus.y_in};
  end

  // One micro-rotation driving y toward zero, plus magnitude saturation.
  always_comb begin
    x_sh_c = x_q >>> cnt_q;
    y_sh_c = y_q >>> cnt_q;
    if (y_q[W-1]) begin
      x_rot_c = x_q - y_sh_c;
      y_rot_c = y_q + x_sh_c;
      z_rot_c = z_q - atan_lut(cnt_q);
    end else begin
      x_rot_c = x_q + y_sh_c;
      y_rot_c = y_q - x_sh_c;
      z_rot_c = z_q + atan_lut(cnt_q);
    end
    mag_sat_c = x_rot_c[W-1] ? {MW{1'b1}} : x_rot_c[MW-1:0];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    angle_d = angle_q;
    mag_d   = mag_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (bus.start) begin
          state_d = ITERATE;
          busy_d  = 1'b1;
          cnt_d   = '0;
          zero_d  = (bus.x_in == '0) && (bus.y_in == '0);
          if (bus.x_in[SZ-1]) begin
            x_d = -x_ext_c;
            y_d = -y_ext_c;
            z_d = 32'h8000_0000;
          end else begin
            x_d = x_ext_c;
            y_d = y_ext_c;
            z_d = '0;
          end
        end
      end
      ITERATE: begin
        x_d   = x_rot_c;
        y_d   = y_rot_c;
        z_d   = z_rot_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          angle_d = zero_q ? '0 : z_rot_c;
          mag_d   = zero_q ? '0 : mag_sat_c;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      angle_q <= '0;
      mag_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.angle     = angle_q;
  assign bus.magnitude = mag_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed bench for cordic_vectoring: vector table, angle sweep and handshake corners.
module tb_cordic_vectoring;

  localparam int unsigned SZ   = 16;
  localparam int unsigned ITER = 16;
  localparam int          ATOL = 1 << 20;
  localparam int          MTOL = 8;
  localparam real         GAIN = 1.646760258;
  localparam real         PI   = 3.14159265358979;

  typedef struct {
    int          x;
    int          y;
    logic [31:0] ang;
    int          ang_tol;
    int          mag;
    int          mag_tol;
  } vec_t;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  cordic_vectoring_if #(.SZ(SZ)) bus ();

  cordic_vectoring #(.SZ(SZ), .ITER(ITER)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input longint got, input longint exp, input longint tol);
    checks++;
    if ((got - exp > tol) || (exp - got > tol)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", name, got, exp, tol);
    end
  endtask

  task automatic chk_angle(input string name, input logic [31:0] got, input logic [31:0] exp, input int tol);
    logic [31:0] diff;
    int          sd;
    diff = got - exp;
    sd   = int'(diff);
    checks++;
    if ((sd > tol) || (sd < -tol)) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (tol %0d)", name, got, exp, tol);
    end
  endtask

  // Pulse start with the given operands and wait (bounded) for done.
  task automatic do_conv(input int x, input int y, output int edges, output int busy_cycles);
    bus.x_in  = SZ'(x);
    bus.y_in  = SZ'(y);
    bus.start = 1'b1;
    tick();
    bus.start   = 1'b0;
    edges       = 0;
    busy_cycles = 0;
    while (!bus.done && edges < 100) begin
      if (bus.busy) busy_cycles++;
      tick();
      edges++;
    end
  endtask

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(-v + 0.5);
  endfunction

  vec_t vecs[9];

  initial begin
    int          edges, busy_cycles, ndone, x, y, m;
    logic [31:0] exp_ang;
    longint unsigned full;
    real         th;

    errors = 0;
    checks = 0;

    vecs[0] = '{x:  19429, y:      0, ang: 32'h0000_0000, ang_tol: ATOL, mag: 31996, mag_tol: MTOL};
    vecs[1] = '{x:      0, y:  19429, ang: 32'h4000_0000, ang_tol: ATOL, mag: 31996, mag_tol: MTOL};
    vecs[2] = '{x:      0, y: -19429, ang: 32'hC000_0000, ang_tol: ATOL, mag: 31996, mag_tol: MTOL};
    vecs[3] = '{x: -19429, y:      0, ang: 32'h8000_0000, ang_tol: ATOL, mag: 31996, mag_tol: MTOL};
    vecs[4] = '{x: -13738, y: -13738, ang: 32'hA000_0000, ang_tol: ATOL, mag: 31995, mag_tol: MTOL};
    vecs[5] = '{x:      0, y:      0, ang: 32'h0000_0000, ang_tol: 0,    mag: 0,     mag_tol: 0};
    vecs[6] = '{x: -32768, y:      0, ang: 32'h8000_0000, ang_tol: ATOL, mag: 53962, mag_tol: MTOL};
    vecs[7] = '{x:   3000, y:   4000, ang: 32'h25C8_0A39, ang_tol: ATOL, mag: 8234,  mag_tol: MTOL};
    vecs[8] = '{x:  30000, y: -30000, ang: 32'hE000_0000, ang_tol: ATOL, mag: 69866, mag_tol: MTOL};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.x_in  = '0;
    bus.y_in  = '0;
    tick();
    tick();
    chk("reset_busy", bus.busy, 0, 0);
    chk("reset_done", bus.done, 0, 0);
    chk("reset_angle", bus.angle, 0, 0);
    chk("reset_mag", bus.magnitude, 0, 0);
    reset = 1'b0;
    tick();

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      do_conv(vecs[i].x, vecs[i].y, edges, busy_cycles);
      chk($sformatf("vec%0d_latency", i), edges, ITER, 0);
      chk($sformatf("vec%0d_busy", i), busy_cycles, ITER, 0);
      chk_angle($sformatf("vec%0d_angle", i), bus.angle, vecs[i].ang, vecs[i].ang_tol);
      chk($sformatf("vec%0d_mag", i), bus.magnitude, vecs[i].mag, vecs[i].mag_tol);
      tick();
      chk($sformatf("vec%0d_done_pulse", i), bus.done, 0, 0);
    end

    // Back-to-back sweep: each start is issued in the DONE cycle of the previous result.
    for (int i = 0; i < 360; i++) begin
      th = real'(i) * PI / 180.0;
      x  = rnd(19429.0 * $cos(th));
      y  = rnd(19429.0 * $sin(th));
      m  = rnd(GAIN * $sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
      full    = (longint'(i) * 64'h1_0000_0000) / 360;
      exp_ang = full[31:0];
      do_conv(x, y, edges, busy_cycles);
      chk($sformatf("sweep%0d_period", i), edges + 1, ITER + 1, 0);
      chk_angle($sformatf("sweep%0d_angle", i), bus.angle, exp_ang, ATOL);
      chk($sformatf("sweep%0d_mag", i), bus.magnitude, m, MTOL);
    end
    tick();

    // Start while busy is ignored; result belongs to the first operands.
    bus.x_in  = SZ'(0);
    bus.y_in  = SZ'(19429);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    bus.x_in  = SZ'(19429);
    bus.y_in  = SZ'(0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    edges = 4;
    while (!bus.done && edges < 100) begin
      tick();
      edges++;
    end
    chk("busy_start_latency", edges, ITER, 0);
    chk_angle("busy_start_angle", bus.angle, 32'h4000_0000, ATOL);
    chk("busy_start_mag", bus.magnitude, 31996, MTOL);
    tick();
    chk("busy_start_no_second_done", bus.busy, 0, 0);

    // Reset in the 8th ITERATE cycle aborts the conversion.
    bus.x_in  = SZ'(-19429);
    bus.y_in  = SZ'(0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("abort_busy_before", bus.busy, 1, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", bus.busy, 0, 0);
    chk("abort_done", bus.done, 0, 0);
    chk("abort_angle", bus.angle, 0, 0);
    chk("abort_mag", bus.magnitude, 0, 0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) ndone++;
      tick();
    end
    chk("abort_no_done", ndone, 0, 0);
    do_conv(0, -19429, edges, busy_cycles);
    chk("after_abort_latency", edges, ITER, 0);
    chk_angle("after_abort_angle", bus.angle, 32'hC000_0000, ATOL);
    chk("after_abort_mag", bus.magnitude, 31996, MTOL);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
